// File: rtl/project_spi_defines.sv
// Shared constants for the SPI register bridge: FSM encodings, frame bit positions, bit counts.
package project_spi_defines;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_WAIT_CS = 2'd3
  } state_e;

  localparam int unsigned RW_BIT     = 7;
  localparam int unsigned ADDR_MSB   = 5;
  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;

endpackage

// File: rtl/project_spi_synchronizer.sv
// Brings the asynchronous SPI pins into the i_clk domain and detects SCLK/CS edges.
module project_spi_synchronizer (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sclk_rise_c,
  output logic sclk_fall_c,
  output logic cs_fall_c,
  output logic cs_n_o,
  output logic mosi_o
);

  logic [2:0] sclk_q;
  logic [2:0] cs_n_q;
  logic [1:0] mosi_q;

  // CS flops reset to "asserted" so a frame already running at reset release
  // produces no falling edge until CS has first returned high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_q <= '0;
      cs_n_q <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      cs_n_q <= {cs_n_q[1:0], cs_n_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  assign sclk_rise_c = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_c = ~sclk_q[1] & sclk_q[2];
  assign cs_fall_c   = ~cs_n_q[1] & cs_n_q[2];
  assign cs_n_o      = cs_n_q[1];
  assign mosi_o      = mosi_q[1];

endmodule

// File: rtl/project_spi_register_bridge.sv
// SPI mode-0 slave bridging {rw,x,addr} + data frames onto a simple register-file port.
// Define SPI_AUTO_INCREMENT_EN for burst access with address auto-increment.
module project_spi_register_bridge
  import project_spi_defines::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned ADDRESS_MAX   = 48
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_spi_sclk,
  input  logic                     i_spi_cs_n,
  input  logic                     i_spi_mosi,
  output logic                     o_spi_miso,
  output logic                     o_write_en,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [7:0]               o_data,
  input  logic [7:0]               i_data,
  output logic                     o_busy
);

  logic sclk_rise, sclk_fall, cs_fall, cs_n, mosi;

  project_spi_synchronizer u_sync (
    .clk_i       (i_clk),
    .reset_i     (i_reset),
    .sclk_i      (i_spi_sclk),
    .cs_n_i      (i_spi_cs_n),
    .mosi_i      (i_spi_mosi),
    .sclk_rise_c (sclk_rise),
    .sclk_fall_c (sclk_fall),
    .cs_fall_c   (cs_fall),
    .cs_n_o      (cs_n),
    .mosi_o      (mosi)
  );

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               mosi_sh_q, mosi_sh_d;
  logic [7:0]               miso_sh_q, miso_sh_d;
  logic                     miso_q, miso_d;
  logic                     rw_q, rw_d;
  logic                     load_q, load_d;
  logic                     incr_q, incr_d;
  logic                     write_en_q, write_en_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [7:0]               data_q, data_d;
  logic                     busy_q;

  logic [7:0] byte_in;
  logic       cmd_done, data_done, in_range;

  assign byte_in   = {mosi_sh_q[6:0], mosi};
  assign cmd_done  = (state_q == ST_CMD) && sclk_rise && (cnt_q == CNT_W'(CMD_BITS - 1));
  assign data_done = (state_q == ST_DATA) && sclk_rise && (cnt_q == CNT_W'(FRAME_BITS - 1));
  assign in_range  = 32'(address_q) <= ADDRESS_MAX;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cs_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (cs_fall) state_d = ST_CMD;
        ST_CMD:     if (cmd_done) state_d = ST_DATA;
        ST_DATA: begin
`ifdef SPI_AUTO_INCREMENT_EN
          state_d = ST_DATA;
`else
          if (data_done) state_d = ST_WAIT_CS;
`endif
        end
        ST_WAIT_CS: state_d = ST_WAIT_CS;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    cnt_d      = cnt_q;
    mosi_sh_d  = mosi_sh_q;
    miso_sh_d  = miso_sh_q;
    miso_d     = miso_q;
    rw_d       = rw_q;
    load_d     = 1'b0;
    incr_d     = 1'b0;
    write_en_d = 1'b0;
    address_d  = address_q;
    data_d     = data_q;

    if (cs_n) begin
      cnt_d  = '0;
      miso_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          miso_d = 1'b0;
        end
        ST_CMD: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            mosi_sh_d = byte_in;
            cnt_d     = cnt_q + CNT_W'(1);
          end
          if (cmd_done) begin
            rw_d      = byte_in[RW_BIT];
            address_d = ADDRESS_WIDTH'(byte_in[ADDR_MSB:ADDR_LSB]);
            load_d    = 1'b1;
          end
        end
        ST_DATA: begin
          // Out-of-range reads and all writes shift out zeros.
          if (load_q) begin
            miso_sh_d = (!rw_q && in_range) ? i_data : 8'h00;
          end else if (sclk_fall) begin
            miso_d    = miso_sh_q[7];
            miso_sh_d = {miso_sh_q[6:0], 1'b0};
          end
          if (sclk_rise) begin
            mosi_sh_d = byte_in;
            cnt_d     = cnt_q + CNT_W'(1);
          end
          if (data_done) begin
            if (rw_q && in_range) begin
              write_en_d = 1'b1;
              data_d     = byte_in;
            end
`ifdef SPI_AUTO_INCREMENT_EN
            cnt_d  = CNT_W'(CMD_BITS);
            incr_d = 1'b1;
`endif
          end
          // Advance after the strobe cycle so the write still sees the old address.
          if (incr_q) begin
            address_d = (address_q == ADDRESS_WIDTH'(ADDRESS_MAX)) ? '0
                                                                   : address_q + ADDRESS_WIDTH'(1);
            load_d    = 1'b1;
          end
        end
        ST_WAIT_CS: miso_d = 1'b0;
        default:    miso_d = 1'b0;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q      <= '0;
      mosi_sh_q  <= '0;
      miso_sh_q  <= '0;
      miso_q     <= 1'b0;
      rw_q       <= 1'b0;
      load_q     <= 1'b0;
      incr_q     <= 1'b0;
      write_en_q <= 1'b0;
      address_q  <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mosi_sh_q  <= mosi_sh_d;
      miso_sh_q  <= miso_sh_d;
      miso_q     <= miso_d;
      rw_q       <= rw_d;
      load_q     <= load_d;
      incr_q     <= incr_d;
      write_en_q <= write_en_d;
      address_q  <= address_d;
      data_q     <= data_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign o_spi_miso = miso_q;
  assign o_write_en = write_en_q;
  assign o_address  = address_q;
  assign o_data     = data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_project_spi_register_bridge.sv
// Directed bench for project_spi_register_bridge with a small register-file model.
module tb_project_spi_register_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, wen, busy;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  logic [7:0] mem [64];
  logic [5:0] wr_a [$];
  logic [7:0] wr_d [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  project_spi_register_bridge dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_spi_sclk (sclk),
    .i_spi_cs_n (cs_n),
    .i_spi_mosi (mosi),
    .o_spi_miso (miso),
    .o_write_en (wen),
    .o_address  (addr),
    .o_data     (wdata),
    .i_data     (rdata),
    .o_busy     (busy)
  );

  assign rdata = mem[addr];

  // Register-file model: record and apply every strobe.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      wr_a.push_back(addr);
      wr_d.push_back(wdata);
      mem[addr] = wdata;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    #60;
    sclk = 1'b1;
    r = miso;
    #60;
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    #60;
  endtask

  task automatic cs_high();
    #60;
    cs_n = 1'b1;
    #100;
  endtask

  task automatic frame2(input logic [7:0] c, input logic [7:0] d, output logic [7:0] rx);
    logic [7:0] dummy;
    cs_low();
    spi_byte(c, dummy);
    spi_byte(d, rx);
    cs_high();
  endtask

  initial begin
    logic [7:0] rx;
    logic       rb;
    int         n0;

    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
    mem[5]    = 8'h3C;
    mem[6'h35] = 8'h77;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(wdata), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0x81,0xA5
    n0 = wr_a.size();
    cs_low();
    spi_byte(8'h81, rx);
    check("wr_busy", 32'(busy), 32'd1);
    spi_byte(8'hA5, rx);
    cs_high();
    check("wr_count", 32'(wr_a.size() - n0), 32'd1);
    check("wr_addr", 32'(wr_a[n0]), 32'h01);
    check("wr_data", 32'(wr_d[n0]), 32'hA5);
    check("hold_addr", 32'(addr), 32'h01);
    check("hold_data", 32'(wdata), 32'hA5);
    check("idle_busy", 32'(busy), 32'd0);

    // Read 0x05 -> 0x3C
    n0 = wr_a.size();
    frame2(8'h05, 8'h00, rx);
    check("rd_byte", 32'(rx), 32'h3C);
    check("rd_nowrite", 32'(wr_a.size() - n0), 32'd0);

    // Out-of-range write and read
    n0 = wr_a.size();
    frame2(8'hB5, 8'hFF, rx);
    check("oor_nowrite", 32'(wr_a.size() - n0), 32'd0);
    frame2(8'h35, 8'h00, rx);
    check("oor_read", 32'(rx), 32'h00);

    // Aborted write then a full one
    n0 = wr_a.size();
    cs_low();
    spi_byte(8'h82, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
    cs_high();
    check("abort_nowrite", 32'(wr_a.size() - n0), 32'd0);
    check("abort_miso", 32'(miso), 32'd0);
    frame2(8'h82, 8'h11, rx);
    check("after_abort_count", 32'(wr_a.size() - n0), 32'd1);
    check("after_abort_addr", 32'(wr_a[n0]), 32'h02);
    check("after_abort_data", 32'(wr_d[n0]), 32'h11);

    // Reset in the middle of a data byte
    n0 = wr_a.size();
    cs_low();
    spi_byte(8'h83, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wen", 32'(wen), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_data", 32'(wdata), 32'd0);
    check("mid_rst_miso", 32'(miso), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
    check("mid_rst_ignored_busy", 32'(busy), 32'd0);
    cs_high();
    check("mid_rst_nowrite", 32'(wr_a.size() - n0), 32'd0);

    // Burst 0xB0,0x01,0x02,0x03
    n0 = wr_a.size();
    cs_low();
    spi_byte(8'hB0, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h02, rx);
    spi_byte(8'h03, rx);
    cs_high();
`ifdef SPI_AUTO_INCREMENT_EN
    check("burst_count", 32'(wr_a.size() - n0), 32'd3);
    check("burst_a0", 32'(wr_a[n0]), 32'h30);
    check("burst_d0", 32'(wr_d[n0]), 32'h01);
    check("burst_a1", 32'(wr_a[n0+1]), 32'h00);
    check("burst_d1", 32'(wr_d[n0+1]), 32'h02);
    check("burst_a2", 32'(wr_a[n0+2]), 32'h01);
    check("burst_d2", 32'(wr_d[n0+2]), 32'h03);
`else
    check("burst_count", 32'(wr_a.size() - n0), 32'd1);
    check("burst_a0", 32'(wr_a[n0]), 32'h30);
    check("burst_d0", 32'(wr_d[n0]), 32'h01);
`endif

    // Read of the highest implemented address
    frame2(8'h30, 8'h00, rx);
    check("rd_max", 32'(rx), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/project_spi_register_bridge.md
PROJECT_SPI_REGISTER_BRIDGE -- requirements
Module: project_spi_register_bridge

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 6: width of the register-file address.
REQ-002 Parameter ADDRESS_MAX, default 48: highest implemented register address.
REQ-003 i_clk  input  1: single system clock; all logic on its rising edge.
REQ-004 i_reset  input  1: synchronous, active-high reset.
REQ-005 i_spi_sclk  input  1: SPI clock from the external host, mode 0 (CPOL=0, CPHA=0), asynchronous to i_clk.
REQ-006 i_spi_cs_n  input  1: SPI chip select, active low, asynchronous.
REQ-007 i_spi_mosi  input  1: SPI serial data in, MSB first, asynchronous.
REQ-008 o_spi_miso  output  1: SPI serial data out, MSB first.
REQ-009 o_write_en  output  1: one-cycle write strobe to the register file.
REQ-010 o_address  output  ADDRESS_WIDTH: register-file address, for both read and write.
REQ-011 o_data  output  8: write data to the register file.
REQ-012 i_data  input  8: combinational read data from the register file at o_address.
REQ-013 o_busy  output  1: high while a frame is in progress (CS asserted, synchronized).

Function
REQ-014 The synchronizer SHALL pass i_spi_sclk, i_spi_cs_n and i_spi_mosi through 2-flop synchronizers, then detect SCLK rise/fall with one further register; the host SHALL keep SCLK high and low for at least 4 i_clk cycles each.
REQ-015 Frame SHALL be: command byte {rw, 1'bx, addr[5:0]} (rw=1 write, rw=0 read), followed by one data byte.
REQ-016 MOSI SHALL be sampled on each detected SCLK rise; MISO SHALL update on each detected SCLK fall.
REQ-017 FSM states SHALL be IDLE, CMD, DATA, WAIT_CS.
  - IDLE->CMD on synchronized CS falling.
  - CMD->DATA after the 8th rise.
  - DATA->WAIT_CS after the 16th rise.
  - Any state->IDLE on synchronized CS high.
REQ-018 On entering DATA, o_address SHALL load addr[5:0].
REQ-019 For a read, one cycle after the address loads, the MISO shift register SHALL load i_data, and o_spi_miso SHALL drive bit 7 before the first data-byte rise.
REQ-020 For a write, o_write_en SHALL pulse high for exactly one i_clk cycle, on the cycle after the 16th rise is detected, with o_data equal to the received byte.
REQ-021 Writes to addresses above ADDRESS_MAX SHALL be dropped (no o_write_en); reads of such addresses SHALL return 0x00 on MISO.
REQ-022 CS deasserting before the 16th rise SHALL abort the frame: no write strobe, bit counter cleared, and o_spi_miso=0.
REQ-023 During CMD and in WAIT_CS, o_spi_miso SHALL be 0.
REQ-024 o_address and o_data SHALL hold their last values between frames.

Reset
REQ-025 While i_reset is high at an i_clk edge, the following SHALL be cleared, overriding any frame in progress:
  - FSM->IDLE; bit counter 0; shift registers 0.
  - o_write_en=0, o_address=0, o_data=0, o_spi_miso=0, o_busy=0.
REQ-026 A frame whose CS falling edge precedes reset release SHALL be ignored until CS returns high.

Configuration
REQ-027 Macro SPI_AUTO_INCREMENT_EN defined: after each data byte, the FSM SHALL stay in DATA, increment o_address (ADDRESS_MAX wraps to 0), and service further bytes with the same rw (burst).
REQ-028 Macro SPI_AUTO_INCREMENT_EN undefined: bytes after the first data byte SHALL be ignored in WAIT_CS.

Structure
REQ-029 A shared defines header (project_spi_defines) SHALL hold the FSM state encodings, frame bit positions (RW bit 7, address bits 5:0) and the bit-count constants 8 and 16.
REQ-030 Sub-module project_spi_synchronizer SHALL implement the 2-flop synchronizers plus SCLK rise/fall and CS fall detection.

Verification
REQ-031 Write frame 0x81,0xA5 -> a single o_write_en pulse with o_address=0x01 and o_data=0xA5.
REQ-032 Read frame 0x05 with i_data=0x3C at address 5 -> MISO byte 0x3C, and o_write_en never asserts.
REQ-033 Write 0xB5,0xFF (addr 0x35 > 48) -> no strobe; read of 0x35 -> MISO 0x00.
REQ-034 Write 0x82 followed by 4 bits, then CS high -> no strobe, and the next full frame 0x82,0x11 writes 0x11.
REQ-035 Assert i_reset mid data byte -> all outputs 0 on the next cycle; no strobe for that frame.
REQ-036 With SPI_AUTO_INCREMENT_EN: write 0xB0,0x01,0x02,0x03 -> strobes at addresses 0x30, 0x00, 0x01; without the macro -> a single strobe at 0x30.
